// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word plus the instruction-cache frame and fill-FSM encodings.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int IIDX_W = 4;
    localparam int ITAG_W = 32 - IIDX_W - 2;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signals of the instruction cache, bundled for port connection.
interface icache_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  iflush;
    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    // The cache itself
    modport slave (
        input  imemREN, imemaddr, iflush, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    // Datapath plus memory controller, seen from outside the cache
    modport master (
        output imemREN, imemaddr, iflush, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-block instruction cache: combinational hit path,
// two-state fill machine on a miss, single-cycle invalidate-all on iflush.
module icache
    import cpu_types_pkg::*;
#(
    parameter  int SETS  = 16,
    localparam int IDX_W = $clog2(SETS),
    localparam int TAG_W = 32 - IDX_W - 2
) (
    input  logic CLK,
    input  logic nRST,
    icache_if.slave cif
);

    icache_state_t state_reg, state_next;
    icache_frame_t frames_reg [SETS];
    word_t         miss_addr_reg;

    logic [IDX_W-1:0] req_idx, miss_idx;
    logic [TAG_W-1:0] req_tag, miss_tag;
    icache_frame_t    req_frame;
    logic             hit;
    logic             fill_done;

    assign req_idx   = cif.imemaddr[IDX_W+1:2];
    assign req_tag   = cif.imemaddr[31:IDX_W+2];
    assign miss_idx  = miss_addr_reg[IDX_W+1:2];
    assign miss_tag  = miss_addr_reg[31:IDX_W+2];
    assign req_frame = frames_reg[req_idx];

    assign hit = (state_reg == IDLE) && cif.imemREN && req_frame.valid
                 && (req_frame.tag == req_tag);

    // A flush in the completing cycle wins: the fetched word is dropped.
    assign fill_done = (state_reg == FILL) && !cif.iwait && !cif.iflush;

    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (!cif.iflush && cif.imemREN && !hit) state_next = FILL;
            FILL: if (cif.iflush || !cif.iwait)           state_next = IDLE;
            default:                                       state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            miss_addr_reg <= '0;
        end else if (state_reg == IDLE && cif.imemREN && !hit) begin
            miss_addr_reg <= cif.imemaddr & ~32'h3;
        end
    end

    // Only valid bits are reset; tag and data are don't-care while invalid.
    always_ff @(posedge CLK, negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < SETS; i++) frames_reg[i].valid <= 1'b0;
        end else if (cif.iflush) begin
            for (int i = 0; i < SETS; i++) frames_reg[i].valid <= 1'b0;
        end else if (fill_done) begin
            frames_reg[miss_idx] <= '{valid: 1'b1, tag: miss_tag, data: cif.iload};
        end
    end

    // iREN/iaddr depend on state and the latched miss address only.
    always_comb begin
        cif.ihit     = 1'b0;
        cif.imemload = '0;
        cif.iREN     = 1'b0;
        cif.iaddr    = '0;
        case (state_reg)
            IDLE: begin
                cif.ihit     = hit;
                cif.imemload = hit ? req_frame.data : '0;
            end
            FILL: begin
                cif.iREN  = 1'b1;
                cif.iaddr = miss_addr_reg;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: the bench acts as memory controller and datapath,
// checks outputs every cycle against a word-address cache model, plus literal expectations.
module tb_icache;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    icache_if bus();

    icache #(.SETS(16)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .cif  (bus)
    );

    int vectors = 0;
    int miscompares = 0;
    int lat = 0;
    int fc;

    function automatic logic [31:0] ram_word(logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h2008_0005;
        return {a[15:0], 16'hC0DE};
    endfunction

    // Memory controller: holds iwait high for 'lat' cycles of each read request.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST)          fc <= 0;
        else if (bus.iREN)  fc <= fc + 1;
        else                fc <= 0;
    end
    assign bus.iwait = bus.iREN && (fc < lat);
    assign bus.iload = ram_word(bus.iaddr);

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Cache model: per-set word address and data, plus an outstanding-miss address.
    bit          m_valid [16];
    logic [29:0] m_word  [16];
    logic [31:0] m_data  [16];
    bit          m_pend;
    logic [31:0] m_pend_addr;

    always @(negedge CLK or negedge nRST) begin : model
        int unsigned idx;
        bit          e_hit;
        logic [31:0] e_load;
        if (!nRST) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
            m_pend = 1'b0;
        end else begin
            idx   = (bus.imemaddr >> 2) % 16;
            e_hit = !m_pend && bus.imemREN && m_valid[idx]
                    && (m_word[idx] == bus.imemaddr[31:2]);
            e_load = e_hit ? m_data[idx] : 32'h0;
            chk("model_ihit",     bus.ihit,     e_hit);
            chk("model_imemload", bus.imemload, e_load);
            chk("model_iREN",     bus.iREN,     m_pend);
            chk("model_iaddr",    bus.iaddr,    m_pend ? m_pend_addr : 32'h0);
            // advance to what the next edge must produce
            if (bus.iflush) begin
                for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
                m_pend = 1'b0;
            end else if (m_pend) begin
                if (!bus.iwait) begin
                    idx = (m_pend_addr >> 2) % 16;
                    m_valid[idx] = 1'b1;
                    m_word[idx]  = m_pend_addr[31:2];
                    m_data[idx]  = ram_word(m_pend_addr);
                    m_pend = 1'b0;
                end
            end else if (bus.imemREN && !e_hit) begin
                m_pend      = 1'b1;
                m_pend_addr = bus.imemaddr & ~32'h3;
            end
        end
    end

    task automatic cyc(bit req, logic [31:0] addr, bit fl);
        @(posedge CLK);
        #1;
        bus.imemREN  = req;
        bus.imemaddr = addr;
        bus.iflush   = fl;
        @(negedge CLK);
    endtask

    task automatic fetch(logic [31:0] addr, output int stalls);
        bit got;
        got = 1'b0;
        stalls = 0;
        for (int i = 0; i < 24 && !got; i++) begin
            cyc(1'b1, addr, 1'b0);
            if (bus.ihit) got = 1'b1;
            else          stalls++;
        end
        if (!got) chk("fetch_bound", bus.ihit, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s;
        bus.imemREN  = 1'b0;
        bus.imemaddr = 32'h0;
        bus.iflush   = 1'b0;
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        chk("reset_ihit",     bus.ihit,     0);
        chk("reset_imemload", bus.imemload, 0);
        chk("reset_iREN",     bus.iREN,     0);
        chk("reset_iaddr",    bus.iaddr,    0);
        @(posedge CLK); #1 nRST = 1'b1;

        // cold miss with three wait cycles
        lat = 3;
        cyc(1'b1, 32'h40, 1'b0);
        chk("cold_c0_ihit", bus.ihit, 0);
        chk("cold_c0_iREN", bus.iREN, 0);
        cyc(1'b1, 32'h40, 1'b0);
        chk("cold_fill_iREN",  bus.iREN,  1);
        chk("cold_fill_iaddr", bus.iaddr, 32'h40);
        chk("cold_fill_ihit",  bus.ihit,  0);
        fetch(32'h40, s);
        chk("cold_stalls_after_c1", s, 3);
        chk("cold_data", bus.imemload, 32'h2008_0005);
        $display("cold miss 0x40: load %h", bus.imemload);

        // repeat hits, byte offset ignored
        cyc(1'b1, 32'h40, 1'b0);
        chk("rehit40_ihit", bus.ihit, 1);
        chk("rehit40_iREN", bus.iREN, 0);
        chk("rehit40_data", bus.imemload, 32'h2008_0005);
        cyc(1'b1, 32'h42, 1'b0);
        chk("rehit42_ihit", bus.ihit, 1);
        chk("rehit42_data", bus.imemload, 32'h2008_0005);
        $display("repeat hit 0x40/0x42: load %h", bus.imemload);

        // conflict eviction in set 0
        lat = 0;
        fetch(32'h80, s);
        chk("conflict80_stalls", s, 2);
        chk("conflict80_data", bus.imemload, 32'h0080_C0DE);
        cyc(1'b1, 32'h40, 1'b0);
        chk("evicted40_ihit", bus.ihit, 0);
        cyc(1'b1, 32'h40, 1'b0);
        chk("evicted40_iREN",  bus.iREN,  1);
        chk("evicted40_iaddr", bus.iaddr, 32'h40);
        fetch(32'h40, s);
        chk("evicted40_refill_stalls", s, 0);
        $display("conflict 0x80 then 0x40: refetched, load %h", bus.imemload);

        // address change during fill
        lat = 3;
        cyc(1'b1, 32'h100, 1'b0);
        chk("mid_c0_ihit", bus.ihit, 0);
        cyc(1'b1, 32'h104, 1'b0);
        chk("mid_iaddr_held", bus.iaddr, 32'h100);
        fetch(32'h104, s);
        chk("mid104_stalls", s, 8);
        chk("mid104_data", bus.imemload, 32'h0104_C0DE);
        cyc(1'b1, 32'h100, 1'b0);
        chk("mid100_ihit", bus.ihit, 1);
        chk("mid100_data", bus.imemload, 32'h0100_C0DE);
        $display("addr change mid-fill: 0x104 stalls %0d, 0x100 hit %0b", s, bus.ihit);

        // flush in IDLE, flush alongside a hit, flush aborting a completing fill
        lat = 0;
        cyc(1'b0, 32'h0, 1'b1);
        cyc(1'b1, 32'h40, 1'b0);
        chk("flush_idle_miss40", bus.ihit, 0);
        fetch(32'h40, s);
        chk("flush_idle_refill_stalls", s, 1);
        cyc(1'b1, 32'h40, 1'b1);
        chk("flush_with_hit_ihit", bus.ihit, 1);
        cyc(1'b1, 32'h40, 1'b0);
        chk("after_flush_hit_ihit", bus.ihit, 0);
        chk("after_flush_hit_iREN", bus.iREN, 0);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0);
        cyc(1'b1, 32'h200, 1'b0);
        chk("fill200_c0_ihit", bus.ihit, 0);
        cyc(1'b0, 32'h200, 1'b1);
        chk("fill200_abort_iREN", bus.iREN, 1);
        cyc(1'b1, 32'h200, 1'b0);
        chk("post_abort_iREN", bus.iREN, 0);
        chk("post_abort_ihit", bus.ihit, 0);
        cyc(1'b1, 32'h200, 1'b0);
        chk("refill200_iREN",  bus.iREN,  1);
        chk("refill200_iaddr", bus.iaddr, 32'h200);
        fetch(32'h200, s);
        chk("refill200_data", bus.imemload, 32'h0200_C0DE);
        $display("flush during fill of 0x200: frame left invalid, refetched");

        // asynchronous reset during a fill
        lat = 5;
        cyc(1'b1, 32'h300, 1'b0);
        cyc(1'b1, 32'h300, 1'b0);
        chk("pre_reset_iREN", bus.iREN, 1);
        #1;
        nRST = 1'b0;
        bus.imemREN = 1'b0;
        #1;
        chk("async_reset_iREN",  bus.iREN,  0);
        chk("async_reset_ihit",  bus.ihit,  0);
        chk("async_reset_iaddr", bus.iaddr, 0);
        @(posedge CLK); #1 nRST = 1'b1;
        lat = 0;
        fetch(32'h40, s);
        chk("post_reset_40_stalls", s, 2);
        fetch(32'h104, s);
        chk("post_reset_104_stalls", s, 2);
        fetch(32'h200, s);
        chk("post_reset_200_stalls", s, 2);
        $display("reset mid-fill: previously filled addresses missed again");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
